keypad_arbiter: RTL
===================

Name: keypad_arbiter

Overview:
- Shares the single matrix-keypad decoder between the operational controller and the setup controller.
- Grants ownership to one requester at a time and drives the decoder enable.
- Routes each decoded digit packet only to the current owner.
- Enforces a one-cycle flush gap on every ownership change and an inactivity timeout, so a stale or abandoned session cannot hold the keypad.
- Sits between the keypad decoder and the operacional/setup blocks, clocked by the divided clock.

Parameters:
- IDLE_TIMEOUT, 5000: clk cycles with no valid digit while granted before forced release (5 s at 1 kHz).
- PRIO_SETUP, 1: on a simultaneous request in IDLE with setup_on low, 1 means setup wins and 0 means operational wins.

Ports:
- clk  in  1  divided system clock
- rst  in  1  asynchronous, active-low reset
- req_op  in  1  operational requests the keypad (level)
- req_setup  in  1  setup requests the keypad (level)
- setup_on  in  1  setup mode active; setup has absolute priority
- kb_digitos_value  in  senhaPac_t  digit packet from the keypad decoder
- kb_digitos_valid  in  1  single-cycle valid from the keypad decoder
- kb_enable  out  1  enable to the keypad decoder
- gnt_op  out  1  operational owns the keypad
- gnt_setup  out  1  setup owns the keypad
- op_digitos_value  out  senhaPac_t  packet routed to operational
- op_digitos_valid  out  1  valid routed to operational
- setup_digitos_value  out  senhaPac_t  packet routed to setup
- setup_digitos_valid  out  1  valid routed to setup
- timeout_pulse  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; idle counter=0; both lockout flags=0.
  - All outputs 0; value outputs all-zero.
- Registered FSM, states IDLE, OWN_OP, OWN_SETUP, DRAIN.
- IDLE:
  - setup_on & req_setup & !lock_setup -> OWN_SETUP.
  - Else !setup_on & req_op & !lock_op -> OWN_OP, unless req_setup & !lock_setup also holds; then PRIO_SETUP decides.
  - Else stay in IDLE.
- OWN_x:
  - Go to DRAIN if req_x deasserts.
  - Go to DRAIN on timeout.
  - In OWN_OP only, go to DRAIN if setup_on rises (preemption).
- DRAIN: exactly one cycle, then IDLE. Arbitration resumes in IDLE on the next cycle, so there are at least 2 cycles between owners.
- Outputs are decoded from state:
  - kb_enable=1 only in OWN_OP/OWN_SETUP.
  - gnt_op=1 only in OWN_OP; gnt_setup=1 only in OWN_SETUP.
- Data routing, combinational, 0-cycle latency:
  - op_digitos_valid = kb_digitos_valid & (state==OWN_OP).
  - setup_digitos_valid is the same, for OWN_SETUP.
  - The owner's value output mirrors kb_digitos_value; the non-owner's value is all-zero.
  - A valid in IDLE or DRAIN is dropped and not buffered.
- Idle counter:
  - Width $clog2(IDLE_TIMEOUT+1).
  - Cleared on entry to OWN_x and on every routed valid; increments each other owned cycle.
  - Saturating; never wraps.
- Timeout:
  - When the counter equals IDLE_TIMEOUT-1 and no valid arrives that cycle: timeout_pulse=1 for that one cycle, go to DRAIN, set lock_x.
  - A valid arriving in that same cycle wins: it is routed, the counter clears, and there is no timeout.
- Lockout: lock_x clears when req_x is seen low. A timed-out requester must drop its request before it can be granted again.
- Simultaneous in OWN_OP: setup_on rise, req_op fall and timeout may coincide. Go to DRAIN, and pulse/lock only if the timeout condition holds.
- setup_on falling while in OWN_SETUP: no effect; release only via req_setup or timeout.
- Reset mid-grant: immediate return to reset values and any in-flight valid is lost.

Decomposition:
- senhaPac_t already lives in the shared package.
- Add to the shared package:
  - arbState_t enum: IDLE, OWN_OP, OWN_SETUP, DRAIN.
  - Constant KB_IDLE_TIMEOUT_DEF = 5000.
- One natural sub-module: timeout_counter, a parameterised saturating counter with clear, enable and terminal-count output.

Test Plan:
- Reset then req_op=1 -> gnt_op=1 and kb_enable=1 on 1st edge; valid with value 7 -> op_digitos_valid=1 same cycle, setup side 0.
- IDLE, req_op=req_setup=1, setup_on=0, PRIO_SETUP=1 -> gnt_setup; drop req_setup -> DRAIN 1 cycle with kb_enable=0 -> gnt_op 2 cycles after the drop.
- OWN_OP, setup_on and req_setup rise -> DRAIN -> IDLE -> OWN_SETUP; a valid injected during DRAIN reaches neither side.
- IDLE_TIMEOUT=8, OWN_OP, no valids -> timeout_pulse on the 8th owned cycle, gnt_op drops; req_op held high -> no re-grant until it goes 0 then 1.
- IDLE_TIMEOUT=8, valid on cycle 7 (terminal cycle) -> no timeout, counter clears; release happens only 8 quiet cycles later.
- rst low mid OWN_SETUP with valid asserted -> all outputs 0 asynchronously; after release with no requests, stays IDLE.

Source files
------------

// File: rtl/keypad_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// keypad_arbiter_pkg
// Shared types for the keypad sharing logic.
//   senhaPac_t          : packed digit packet produced by the keypad decoder
//                         (four BCD nibbles, d0 = most recent digit)
//   arbState_t          : ownership state of the keypad arbiter
//   KB_IDLE_TIMEOUT_DEF : default inactivity window in clk cycles
//                         (5 s at the 1 kHz divided clock)
// -----------------------------------------------------------------------------
package keypad_arbiter_pkg;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } senhaPac_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OWN_OP    = 2'd1,
    OWN_SETUP = 2'd2,
    DRAIN     = 2'd3
  } arbState_t;

  localparam int KB_IDLE_TIMEOUT_DEF = 5000;

endpackage

// File: rtl/keypad_arbiter_timeout_counter.sv
// -----------------------------------------------------------------------------
// timeout_counter
// Saturating up-counter used as the inactivity timer of the keypad arbiter.
//   clk   in  clock
//   rst   in  asynchronous active-low reset (count -> 0)
//   i_clr in  synchronous clear, dominates i_en
//   i_en  in  count enable
//   o_tc  out high while the count sits at LIMIT-1, i.e. during the last
//             cycle of a LIMIT-cycle window that started at count 0
// The count stops at LIMIT so it can never wrap back into a "fresh" value.
// -----------------------------------------------------------------------------
module timeout_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/keypad_arbiter.sv
// -----------------------------------------------------------------------------
// keypad_arbiter
// Shares the single matrix-keypad decoder between the operational controller
// and the setup controller. One owner at a time; every ownership change goes
// through a one-cycle DRAIN plus one IDLE arbitration cycle, and an owner that
// stays silent for IDLE_TIMEOUT cycles is forcibly released and locked out
// until it drops its request.
//
// Ports:
//   clk                 in  divided system clock
//   rst                 in  asynchronous active-low reset
//   req_op / req_setup  in  level requests from the two controllers
//   setup_on            in  setup mode active (setup has absolute priority)
//   kb_digitos_value    in  digit packet from the keypad decoder
//   kb_digitos_valid    in  single-cycle valid from the keypad decoder
//   kb_enable           out enable to the keypad decoder (while owned)
//   gnt_op / gnt_setup  out current owner
//   op_digitos_*        out packet/valid routed to operational
//   setup_digitos_*     out packet/valid routed to setup
//   timeout_pulse       out one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module keypad_arbiter
  import keypad_arbiter_pkg::*;
#(
  parameter int   IDLE_TIMEOUT = KB_IDLE_TIMEOUT_DEF,
  parameter logic PRIO_SETUP   = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_op,
  input  logic      req_setup,
  input  logic      setup_on,
  input  senhaPac_t kb_digitos_value,
  input  logic      kb_digitos_valid,
  output logic      kb_enable,
  output logic      gnt_op,
  output logic      gnt_setup,
  output senhaPac_t op_digitos_value,
  output logic      op_digitos_valid,
  output senhaPac_t setup_digitos_value,
  output logic      setup_digitos_valid,
  output logic      timeout_pulse
);

  arbState_t r_state;
  logic      r_lock_op;
  logic      r_lock_setup;

  logic w_own_op;
  logic w_own_setup;
  logic w_owned;
  logic w_tc;
  logic w_timeout;
  logic w_want_op;
  logic w_want_setup;

  assign w_own_op     = (r_state == OWN_OP);
  assign w_own_setup  = (r_state == OWN_SETUP);
  assign w_owned      = w_own_op | w_own_setup;
  assign w_want_op    = req_op & ~r_lock_op;
  assign w_want_setup = req_setup & ~r_lock_setup;

  // A valid in the terminal cycle wins over the timeout.
  assign w_timeout = w_owned & w_tc & ~kb_digitos_valid;

  // Held at zero while unowned, so every grant starts from a clean window;
  // any routed digit restarts the window.
  timeout_counter #(
    .LIMIT (IDLE_TIMEOUT)
  ) u_timeout_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (~w_owned | kb_digitos_valid),
    .i_en  (w_owned),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lock_op    <= 1'b0;
      r_lock_setup <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (setup_on && w_want_setup) begin
            r_state <= OWN_SETUP;
          end else if (!setup_on && w_want_op) begin
            // Tie-break only matters when setup is also eligible.
            r_state <= (w_want_setup && PRIO_SETUP) ? OWN_SETUP : OWN_OP;
          end
        end
        OWN_OP: begin
          // setup_on can only be high here if it rose after the grant.
          if (!req_op || setup_on || w_timeout) begin
            r_state <= DRAIN;
          end
        end
        OWN_SETUP: begin
          if (!req_setup || w_timeout) begin
            r_state <= DRAIN;
          end
        end
        DRAIN:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Setting the lock takes precedence over the release in the same cycle.
      if (w_timeout && w_own_op) begin
        r_lock_op <= 1'b1;
      end else if (!req_op) begin
        r_lock_op <= 1'b0;
      end

      if (w_timeout && w_own_setup) begin
        r_lock_setup <= 1'b1;
      end else if (!req_setup) begin
        r_lock_setup <= 1'b0;
      end
    end
  end

  assign kb_enable     = w_owned;
  assign gnt_op        = w_own_op;
  assign gnt_setup     = w_own_setup;
  assign timeout_pulse = w_timeout;

  // Zero-latency routing; digits arriving while unowned are simply dropped.
  assign op_digitos_valid    = kb_digitos_valid & w_own_op;
  assign setup_digitos_valid = kb_digitos_valid & w_own_setup;
  assign op_digitos_value    = w_own_op    ? kb_digitos_value : '0;
  assign setup_digitos_value = w_own_setup ? kb_digitos_value : '0;

endmodule
